// File: rtl/mul_hilo_unit_pkg.sv
// Shared execute-stage definitions: function codes for the ALU and the HI/LO multiply unit,
// plus the multiply FSM state encoding.
package mul_hilo_unit_pkg;

  localparam int unsigned FN_W = 6;

  // ALU function codes
  localparam logic [FN_W-1:0] FN_ADD = 6'b100000;
  localparam logic [FN_W-1:0] FN_SUB = 6'b100010;
  localparam logic [FN_W-1:0] FN_AND = 6'b100100;
  localparam logic [FN_W-1:0] FN_OR  = 6'b100101;
  localparam logic [FN_W-1:0] FN_SLT = 6'b101010;

  // HI/LO unit function codes
  localparam logic [FN_W-1:0] FN_MULTU = 6'b011001;
  localparam logic [FN_W-1:0] FN_MULT  = 6'b011000;
  localparam logic [FN_W-1:0] FN_MFHI  = 6'b010000;
  localparam logic [FN_W-1:0] FN_MFLO  = 6'b010010;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/mul_hilo_unit_if.sv
// Execute-stage bus shared between the ALU and the HI/LO multiply unit.
interface mul_hilo_unit_if
  import mul_hilo_unit_pkg::*;
#(
  parameter int unsigned WIDTH = 32
);
  logic [WIDTH-1:0] dataA;
  logic [WIDTH-1:0] dataB;
  logic [FN_W-1:0]  Signal;
  logic [WIDTH-1:0] aluOut;
  logic [WIDTH-1:0] dataOut;
  logic             busy;
  logic             done;

  modport master (
    output dataA, dataB, Signal, aluOut,
    input  dataOut, busy, done
  );

  modport slave (
    input  dataA, dataB, Signal, aluOut,
    output dataOut, busy, done
  );
endinterface

// File: rtl/mul_hilo_unit_mul_step.sv
// One shift-add multiply iteration: conditional 33-bit add into the upper half, then shift right.
module mul_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [2*WIDTH:0]   prod_i,
  input  logic [WIDTH-1:0]   mcand_i,
  output logic [2*WIDTH:0]   prod_c
);
  logic [WIDTH:0] upper;

  always_comb begin
    upper = prod_i[2*WIDTH:WIDTH];
    if (prod_i[0]) begin
      upper = {1'b0, prod_i[2*WIDTH-1:WIDTH]} + {1'b0, mcand_i};
    end
    prod_c = {1'b0, upper, prod_i[WIDTH-1:1]};
  end
endmodule

// File: rtl/mul_hilo_unit.sv
// Sequential 32-step HI/LO multiplier and execute-stage result mux.
// Define MUL_SIGNED_EN to add the signed MULT function.
module mul_hilo_unit
  import mul_hilo_unit_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 5
) (
  input logic             clk,
  input logic             reset,
  mul_hilo_unit_if.slave  bus
);
  localparam int unsigned     PROD_W   = 2*WIDTH + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_e              state_q, state_d;
  logic [WIDTH-1:0]    mcand_q, mcand_d;
  logic [WIDTH-1:0]    hi_q, hi_d;
  logic [WIDTH-1:0]    lo_q, lo_d;
  logic [PROD_W-1:0]   prod_q, prod_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  logic [PROD_W-1:0]   prod_step_c;
  logic                start_c;
  logic [WIDTH-1:0]    op_a_c, op_b_c;
  logic [2*WIDTH-1:0]  result_c;
`ifdef MUL_SIGNED_EN
  logic                neg_q, neg_d;
`endif

  mul_step #(.WIDTH(WIDTH)) u_mul_step (
    .prod_i  (prod_q),
    .mcand_i (mcand_q),
    .prod_c  (prod_step_c)
  );

  // Start decode, operand conditioning and commit value
  always_comb begin
    start_c  = (bus.Signal == FN_MULTU);
    op_a_c   = bus.dataA;
    op_b_c   = bus.dataB;
    result_c = prod_step_c[2*WIDTH-1:0];
`ifdef MUL_SIGNED_EN
    if (bus.Signal == FN_MULT) begin
      start_c = 1'b1;
      op_a_c  = bus.dataA[WIDTH-1] ? -bus.dataA : bus.dataA;
      op_b_c  = bus.dataB[WIDTH-1] ? -bus.dataB : bus.dataB;
    end
    if (neg_q) begin
      result_c = -prod_step_c[2*WIDTH-1:0];
    end
`endif
  end

  always_comb begin
    state_d = state_q;
    mcand_d = mcand_q;
    prod_d  = prod_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
`ifdef MUL_SIGNED_EN
    neg_d   = neg_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (start_c) begin
          state_d = MUL;
          mcand_d = op_a_c;
          prod_d  = {{(WIDTH+1){1'b0}}, op_b_c};
          cnt_d   = '0;
`ifdef MUL_SIGNED_EN
          neg_d   = (bus.Signal == FN_MULT) && (bus.dataA[WIDTH-1] ^ bus.dataB[WIDTH-1]);
`endif
        end
      end
      MUL: begin
        prod_d = prod_step_c;
        cnt_d  = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_CNT) begin
          hi_d    = result_c[2*WIDTH-1:WIDTH];
          lo_d    = result_c[WIDTH-1:0];
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == MUL);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      mcand_q <= '0;
      prod_q  <= '0;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef MUL_SIGNED_EN
      neg_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      mcand_q <= mcand_d;
      prod_q  <= prod_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef MUL_SIGNED_EN
      neg_q   <= neg_d;
`endif
    end
  end

  // Execute-stage result select; MFHI/MFLO read committed values with no forwarding
  always_comb begin
    case (bus.Signal)
      FN_MFHI:  bus.dataOut = hi_q;
      FN_MFLO:  bus.dataOut = lo_q;
      FN_MULTU: bus.dataOut = '0;
`ifdef MUL_SIGNED_EN
      FN_MULT:  bus.dataOut = '0;
`endif
      default:  bus.dataOut = bus.aluOut;
    endcase
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;

endmodule

// File: tb/tb_mul_hilo_unit.sv
// Self-checking bench for mul_hilo_unit: vector tables, random multiplies against a 64-bit
// arithmetic model, and hand sequences for ignored starts and mid-multiply reset.
module tb_mul_hilo_unit;
  import mul_hilo_unit_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   failures = 0;
  logic [63:0] hilo_model = 64'd0;

  mul_hilo_unit_if bus ();

  mul_hilo_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  fn;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] prod;
    int          inj;
  } mul_vec_t;

  typedef struct {
    logic [5:0]  fn;
    logic [31:0] alu;
    logic [31:0] exp;
  } pass_vec_t;

  function automatic mul_vec_t mk_mul(input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b,
                                      input logic [63:0] prod, input int inj);
    mul_vec_t v;
    v.fn = fn; v.a = a; v.b = b; v.prod = prod; v.inj = inj;
    return v;
  endfunction

  function automatic pass_vec_t mk_pass(input logic [5:0] fn, input logic [31:0] alu, input logic [31:0] exp);
    pass_vec_t v;
    v.fn = fn; v.alu = alu; v.exp = exp;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Reads HI and LO through the result mux without an intervening clock edge.
  task automatic read_hilo(output logic [63:0] val);
    logic [5:0] saved;
    saved = bus.Signal;
    bus.Signal = FN_MFHI;
    #1 val[63:32] = bus.dataOut;
    bus.Signal = FN_MFLO;
    #1 val[31:0] = bus.dataOut;
    bus.Signal = saved;
  endtask

  // Runs one multiply; inj >= 0 presents a second start at that cycle, which must be ignored.
  task automatic run_seq(input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] exp, input int inj, input string name);
    int busy_n = 0;
    int done_n = 0;
    int done_at = -1;
    int overlap = 0;
    logic [63:0] got;
    @(negedge clk);
    bus.Signal = fn;
    bus.dataA  = a;
    bus.dataB  = b;
    #1 check({name, "_start_out"}, 64'(bus.dataOut), 64'd0);
    @(negedge clk);
    bus.Signal = FN_ADD;
    bus.dataA  = $urandom;
    bus.dataB  = $urandom;
    for (int i = 0; i < 40; i++) begin
      if (bus.busy) busy_n++;
      if (bus.done) begin
        done_n++;
        if (done_at < 0) done_at = i;
      end
      if (bus.busy && bus.done) overlap++;
      if (i == inj) begin
        bus.Signal = fn;
        bus.dataA  = 32'd7;
        bus.dataB  = 32'd7;
      end else if (i == inj + 1) begin
        bus.Signal = FN_ADD;
      end
      if (i == 10) begin
        bus.Signal = FN_MFLO;
        #1 check({name, "_mid_lo"}, 64'(bus.dataOut), 64'(hilo_model[31:0]));
        bus.Signal = FN_MFHI;
        #1 check({name, "_mid_hi"}, 64'(bus.dataOut), 64'(hilo_model[63:32]));
        bus.Signal = FN_ADD;
        bus.aluOut = 32'hA5A5A5A5;
        #1 check({name, "_mid_alu"}, 64'(bus.dataOut), 64'hA5A5A5A5);
      end
      @(negedge clk);
    end
    check({name, "_busy_cycles"}, 64'(busy_n), 64'd32);
    check({name, "_done_pulses"}, 64'(done_n), 64'd1);
    check({name, "_done_cycle"}, 64'(done_at), 64'd32);
    check({name, "_overlap"}, 64'(overlap), 64'd0);
    read_hilo(got);
    check({name, "_hilo"}, got, exp);
    hilo_model = exp;
  endtask

  mul_vec_t  mv[$];
  pass_vec_t pv[$];

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [63:0] got;
    logic [31:0] ra, rb;
    int busy_n, done_n;

    mv.push_back(mk_mul(FN_MULTU, 32'd3, 32'd5, 64'd15, -1));
    mv.push_back(mk_mul(FN_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001, -1));
    mv.push_back(mk_mul(FN_MULTU, 32'h80000000, 32'd2, 64'h00000001_00000000, -1));
    mv.push_back(mk_mul(FN_MULTU, 32'h00010000, 32'h00010000, 64'h00000001_00000000, -1));
    mv.push_back(mk_mul(FN_MULTU, 32'd1, 32'hFFFFFFFF, 64'h00000000_FFFFFFFF, -1));
    mv.push_back(mk_mul(FN_MULTU, 32'd0, 32'hDEADBEEF, 64'd0, 32));
    mv.push_back(mk_mul(FN_MULTU, 32'h1234, 32'd1, 64'h1234, -1));
    mv.push_back(mk_mul(FN_MULTU, 32'd3, 32'd5, 64'd15, 5));
`ifdef MUL_SIGNED_EN
    mv.push_back(mk_mul(FN_MULT, 32'hFFFFFFFE, 32'd3, 64'hFFFFFFFF_FFFFFFFA, -1));
    mv.push_back(mk_mul(FN_MULT, 32'hFFFFFFFB, 32'hFFFFFFF9, 64'd35, -1));
    mv.push_back(mk_mul(FN_MULT, 32'h80000000, 32'h80000000, 64'h40000000_00000000, -1));
    mv.push_back(mk_mul(FN_MULT, 32'h80000000, 32'd1, 64'hFFFFFFFF_80000000, -1));
`endif

    pv.push_back(mk_pass(FN_ADD, 32'hA5A5A5A5, 32'hA5A5A5A5));
    pv.push_back(mk_pass(FN_SUB, 32'h00000001, 32'h00000001));
    pv.push_back(mk_pass(FN_AND, 32'h0F0F0F0F, 32'h0F0F0F0F));
    pv.push_back(mk_pass(FN_OR,  32'hFFFF0000, 32'hFFFF0000));
    pv.push_back(mk_pass(FN_SLT, 32'h00000001, 32'h00000001));
    pv.push_back(mk_pass(6'd0,   32'h13579BDF, 32'h13579BDF));
    pv.push_back(mk_pass(6'd63,  32'h2468ACE0, 32'h2468ACE0));
`ifndef MUL_SIGNED_EN
    pv.push_back(mk_pass(6'd24,  32'hCAFEF00D, 32'hCAFEF00D));
`endif

    // Reset state
    bus.Signal = FN_ADD;
    bus.aluOut = 32'hDEADBEEF;
    bus.dataA  = 32'd0;
    bus.dataB  = 32'd0;
    #1 check("rst_dataout", 64'(bus.dataOut), 64'hDEADBEEF);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_done", 64'(bus.done), 64'd0);
    read_hilo(got);
    check("rst_hilo", got, 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Passthrough table: no multiply may start for ALU codes
    foreach (pv[k]) begin
      @(negedge clk);
      bus.Signal = pv[k].fn;
      bus.aluOut = pv[k].alu;
      #1 check($sformatf("pass_out_%0d", k), 64'(bus.dataOut), 64'(pv[k].exp));
      @(negedge clk);
      check($sformatf("pass_busy_%0d", k), 64'(bus.busy), 64'd0);
    end

    // Directed multiply table
    foreach (mv[k]) begin
      run_seq(mv[k].fn, mv[k].a, mv[k].b, mv[k].prod, mv[k].inj, $sformatf("mul_%0d", k));
    end

    // Random unsigned multiplies against 64-bit arithmetic
    for (int k = 0; k < 16; k++) begin
      ra = $urandom;
      rb = $urandom;
      if (k == 0) rb = 32'hFFFFFFFF;
      run_seq(FN_MULTU, ra, rb, {32'd0, ra} * {32'd0, rb}, -1, $sformatf("rnd_%0d", k));
    end
`ifdef MUL_SIGNED_EN
    for (int k = 0; k < 8; k++) begin
      ra = $urandom;
      rb = $urandom;
      run_seq(FN_MULT, ra, rb, 64'($signed({{32{ra[31]}}, ra}) * $signed({{32{rb[31]}}, rb})), -1,
              $sformatf("srnd_%0d", k));
    end
`endif

    // Mid-multiply reset aborts without committing
    run_seq(FN_MULTU, 32'h80000001, 32'd2, 64'h00000001_00000002, -1, "pre_rst");
    @(negedge clk);
    bus.Signal = FN_MULTU;
    bus.dataA  = 32'd3;
    bus.dataB  = 32'd5;
    @(negedge clk);
    bus.Signal = FN_ADD;
    repeat (9) @(negedge clk);
    reset = 1'b1;
    #1 check("abort_busy", 64'(bus.busy), 64'd0);
    read_hilo(got);
    check("abort_hilo", got, 64'd0);
    hilo_model = 64'd0;
    @(negedge clk);
    reset = 1'b0;
    busy_n = 0;
    done_n = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.busy) busy_n++;
      if (bus.done) done_n++;
      @(negedge clk);
    end
    check("abort_no_busy", 64'(busy_n), 64'd0);
    check("abort_no_done", 64'(done_n), 64'd0);
    run_seq(FN_MULTU, 32'd2, 32'd2, 64'd4, -1, "post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
